// File: rtl/flash_arbiter.sv
// Round-robin share of one flash byte-read engine among three req/ack ports, with a transfer watchdog.
// Grant to flash_cs/flash_addr takes 1 cycle; requests wait while a transfer runs, ack + 3 cycles between grants.
module flash_arbiter #(
    parameter int TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [2:0]  req,
    input  logic [23:0] addr0,
    input  logic [23:0] addr1,
    input  logic [23:0] addr2,
    output logic [2:0]  ack,
    output logic        err,
    output logic [7:0]  rdata,
    output logic        arb_busy,
    input  logic        flash_ready,
    output logic        flash_cs,
    output logic [23:0] flash_addr,
    input  logic        flash_busy,
    input  logic [7:0]  flash_dout
);
    localparam logic [5:0] TMO = 6'(TIMEOUT);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t      r_state;
    logic [1:0]  r_last;
    logic [1:0]  r_gap;
    logic [5:0]  r_cnt;
    logic        r_cs;
    logic [23:0] r_addr;
    logic [2:0]  r_ack;
    logic        r_err;
    logic [7:0]  r_rdata;
    logic        r_busy;

    logic [1:0]  w_win;
    logic [23:0] w_addr;
    logic [2:0]  w_ack_oh;
    logic [5:0]  w_cnt_nxt;
    logic        w_tmo;

    // Search starts one past the previous winner so every port waits at most two transfers.
    always_comb begin
        w_win = r_last;
        case (r_last)
            2'd0:    w_win = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    w_win = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: w_win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
        case (w_win)
            2'd0:    w_addr = addr0;
            2'd1:    w_addr = addr1;
            default: w_addr = addr2;
        endcase
        w_ack_oh  = 3'b001 << r_last;
        w_cnt_nxt = r_cnt + 6'd1;
        w_tmo     = (w_cnt_nxt == TMO);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_INIT;
            r_last  <= 2'd2;
            r_gap   <= 2'd0;
            r_cnt   <= 6'd0;
            r_cs    <= 1'b0;
            r_addr  <= 24'd0;
            r_ack   <= 3'd0;
            r_err   <= 1'b0;
            r_rdata <= 8'h00;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    if (flash_ready) r_state <= S_IDLE;
                end
                S_IDLE: begin
                    if (|req) begin
                        r_addr  <= w_addr;
                        r_cs    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_last  <= w_win;
                        r_cnt   <= 6'd0;
                        r_state <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    if (flash_busy) begin
                        r_cs    <= 1'b0;
                        r_cnt   <= 6'd0;
                        r_state <= S_WAIT_DONE;
                    end else if (w_tmo) begin
                        r_cs    <= 1'b0;
                        r_rdata <= 8'hFF;
                        r_ack   <= w_ack_oh;
                        r_err   <= 1'b1;
                        r_gap   <= 2'd0;
                        r_state <= S_GAP;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                S_WAIT_DONE: begin
                    if (!flash_busy) begin
                        r_rdata <= flash_dout;
                        r_ack   <= w_ack_oh;
                        r_gap   <= 2'd0;
                        r_state <= S_GAP;
                    end else if (w_tmo) begin
                        r_rdata <= 8'hFF;
                        r_ack   <= w_ack_oh;
                        r_err   <= 1'b1;
                        r_gap   <= 2'd0;
                        r_state <= S_GAP;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                S_GAP: begin
                    // Ack cycle plus two more keeps cs low long enough for the engine's synchronizer.
                    r_ack <= 3'd0;
                    r_err <= 1'b0;
                    if (r_gap == 2'd2) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + 2'd1;
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

    assign ack        = r_ack;
    assign err        = r_err;
    assign rdata      = r_rdata;
    assign arb_busy   = r_busy;
    assign flash_cs   = r_cs;
    assign flash_addr = r_addr;
endmodule

// File: tb/tb_flash_arbiter.sv
// Bench for flash_arbiter: directed scenarios plus randomized requesters, checked each cycle against a behavioural model.
module tb_flash_arbiter;
    localparam int TIMEOUT = 63;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [2:0]  req;
    logic [23:0] addr0, addr1, addr2;
    logic [2:0]  ack;
    logic        err;
    logic [7:0]  rdata;
    logic        arb_busy;
    logic        flash_ready;
    logic        flash_cs;
    logic [23:0] flash_addr;
    logic        flash_busy;
    logic [7:0]  flash_dout;

    flash_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .resetn(resetn), .req(req),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .ack(ack), .err(err), .rdata(rdata), .arb_busy(arb_busy),
        .flash_ready(flash_ready), .flash_cs(flash_cs), .flash_addr(flash_addr),
        .flash_busy(flash_busy), .flash_dout(flash_dout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // Requesters: raise when wanted, hold until ack, drop on the edge after ack.
    logic [2:0]  want;
    logic [23:0] want_addr [3];
    bit          rand_mode;
    logic [2:0]  ack_prev;

    task automatic set_addr(input int p, input logic [23:0] v);
        case (p)
            0:       addr0 = v;
            1:       addr1 = v;
            default: addr2 = v;
        endcase
    endtask

    initial begin
        logic go;
        req = 3'b000; addr0 = '0; addr1 = '0; addr2 = '0; ack_prev = 3'b000;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                if (ack_prev[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i]) begin
                    go = rand_mode ? ($urandom_range(0, 3) == 0) : want[i];
                    if (go) begin
                        set_addr(i, rand_mode ? 24'($urandom) : want_addr[i]);
                        req[i] = 1'b1;
                    end
                end
            end
            ack_prev = ack;
        end
    end

    // Flash engine: 3-stage cs sync, busy for a few cycles, data = xor of address bytes ^ 0x3C.
    int         eng_mode;   // 0 normal, 1 never busy, 2 busy stuck high
    int         eng_len;    // 0 selects a random length
    bit         eng_force;
    logic [7:0] eng_force_data;

    initial begin
        logic s1, s2, s3, rise;
        int   cnt;
        logic [7:0] data;
        flash_busy = 1'b0; flash_dout = 8'h00;
        s1 = 0; s2 = 0; s3 = 0; cnt = 0; data = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (!resetn) begin
                flash_busy = 1'b0; flash_dout = 8'h00;
                s1 = 0; s2 = 0; s3 = 0; cnt = 0;
            end else begin
                s3 = s2; s2 = s1; s1 = flash_cs;
                rise = s2 && !s3;
                if (flash_busy) begin
                    if (eng_mode != 2) begin
                        cnt--;
                        if (cnt <= 0) begin
                            flash_busy = 1'b0;
                            flash_dout = data;
                        end
                    end
                end else if (rise && eng_mode != 1) begin
                    flash_busy = 1'b1;
                    cnt  = (eng_len == 0) ? int'($urandom_range(1, 6)) : eng_len;
                    data = eng_force ? eng_force_data
                         : (flash_addr[7:0] ^ flash_addr[15:8] ^ flash_addr[23:16] ^ 8'h3C);
                end
            end
        end
    end

    // Behavioural model: per-cycle expected outputs derived from the transfer phases.
    typedef enum int {P_INIT, P_READY, P_WAIT_START, P_WAIT_END} ph_t;
    ph_t         ph;
    int          ph_start, idle_from, m_last;
    logic        e_cs, e_err, e_abusy;
    logic [23:0] e_addr;
    logic [2:0]  e_ack;
    logic [7:0]  e_rdata;

    function automatic logic [23:0] port_addr(input int p);
        case (p)
            0:       return addr0;
            1:       return addr1;
            default: return addr2;
        endcase
    endfunction

    task automatic complete(input bit is_err, input logic [7:0] d);
        e_ack     = 3'(1 << m_last);
        e_err     = is_err;
        e_rdata   = d;
        e_cs      = 1'b0;
        ph        = P_READY;
        idle_from = cyc + 4;
    endtask

    initial begin
        int p;
        forever begin
            @(negedge clk);
            cyc++;
            if (!resetn) begin
                ph = P_INIT; m_last = 2;
                e_cs = 0; e_addr = '0; e_ack = '0; e_err = 0; e_rdata = 8'h00; e_abusy = 0;
            end
            check("flash_cs", flash_cs, e_cs);
            check("flash_addr", flash_addr, e_addr);
            check("ack", ack, e_ack);
            check("err", err, e_err);
            check("rdata", rdata, e_rdata);
            check("arb_busy", arb_busy, e_abusy);
            if (resetn) begin
                e_ack = '0;
                e_err = 1'b0;
                case (ph)
                    P_INIT: begin
                        if (flash_ready) begin
                            ph = P_READY;
                            idle_from = cyc + 1;
                        end
                    end
                    P_READY: begin
                        if (cyc + 1 == idle_from) e_abusy = 1'b0;
                        if (cyc >= idle_from && req != 3'b000) begin
                            for (int k = 1; k <= 3; k++) begin
                                p = (m_last + k) % 3;
                                if (req[p]) break;
                            end
                            m_last   = p;
                            e_cs     = 1'b1;
                            e_addr   = port_addr(p);
                            e_abusy  = 1'b1;
                            ph       = P_WAIT_START;
                            ph_start = cyc + 1;
                        end
                    end
                    P_WAIT_START: begin
                        if (flash_busy) begin
                            e_cs     = 1'b0;
                            ph       = P_WAIT_END;
                            ph_start = cyc + 1;
                        end else if (cyc - ph_start + 1 == TIMEOUT) begin
                            complete(1'b1, 8'hFF);
                        end
                    end
                    default: begin
                        if (!flash_busy) complete(1'b0, flash_dout);
                        else if (cyc - ph_start + 1 == TIMEOUT) complete(1'b1, 8'hFF);
                    end
                endcase
            end
        end
    end

    // Bounded waits, sampled just after the negedge model update.
    task automatic wait_cs_rise(input string name, output int at);
        logic p;
        bit   found;
        found = 0; at = -1;
        p = flash_cs;
        for (int n = 0; n < 300 && !found; n++) begin
            @(negedge clk); #1;
            if (flash_cs && !p) begin found = 1; at = cyc; end
            p = flash_cs;
        end
        check({name, "_cs_rise_seen"}, 32'(found), 32'd1);
    endtask

    task automatic wait_ack(input string name, output int at);
        bit found;
        found = 0; at = -1;
        for (int n = 0; n < 300 && !found; n++) begin
            @(negedge clk); #1;
            if (ack != 3'b000) begin found = 1; at = cyc; end
        end
        check({name, "_ack_seen"}, 32'(found), 32'd1);
    endtask

    task automatic drain(input string name);
        bit done;
        done = 0;
        for (int n = 0; n < 2000 && !done; n++) begin
            @(negedge clk); #1;
            if (req == 3'b000 && !arb_busy) done = 1;
        end
        check({name, "_drained"}, 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        resetn = 1'b0; flash_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1 flash_ready = 1'b1;
    endtask

    initial begin
        int r, a, c0;
        logic [2:0] exp_order [6];
        rand_mode = 0; want = 3'b000; flash_ready = 1'b0;
        eng_mode = 0; eng_len = 0; eng_force = 0; eng_force_data = 8'h00;
        for (int i = 0; i < 3; i++) want_addr[i] = '0;

        // Ready held low after reset with port 0 requesting
        want_addr[0] = 24'h0ABCDE;
        want = 3'b001;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            check("cs_low_before_ready", flash_cs, 1'b0);
        end
        @(posedge clk); #1;
        flash_ready = 1'b1;
        c0 = cyc + 1;
        wait_cs_rise("t1", r);
        want = 3'b000;
        check("t1_grant_latency", r - c0, 2);
        check("t1_addr", flash_addr, 24'h0ABCDE);
        wait_ack("t1", a);
        check("t1_ack", ack, 3'b001);
        check("t1_rdata", rdata, 8'h54);
        drain("t1");

        // Single read on port 1 with fixed engine data
        eng_force = 1; eng_force_data = 8'hA5;
        want_addr[1] = 24'h123456;
        want = 3'b010;
        wait_cs_rise("t2", r);
        want = 3'b000;
        wait_ack("t2", a);
        check("t2_ack", ack, 3'b010);
        check("t2_err", err, 1'b0);
        check("t2_rdata", rdata, 8'hA5);
        check("t2_addr", flash_addr, 24'h123456);
        eng_force = 0;
        drain("t2");

        // All ports requesting continuously
        do_reset();
        want_addr[0] = 24'h000100; want_addr[1] = 24'h000200; want_addr[2] = 24'h000300;
        want = 3'b111;
        exp_order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        for (int i = 0; i < 6; i++) begin
            wait_ack("t3", a);
            check("t3_order", ack, exp_order[i]);
            if (i < 5) begin
                wait_cs_rise("t3", r);
                check("t3_spacing", r - a, 4);
            end
        end
        want = 3'b000;
        drain("t3");

        // Engine never raises busy
        eng_mode = 1;
        want_addr[2] = 24'hABCDEF;
        want = 3'b100;
        wait_cs_rise("t4", r);
        want = 3'b000;
        wait_ack("t4", a);
        check("t4_timeout_cycles", a - r, TIMEOUT);
        check("t4_ack", ack, 3'b100);
        check("t4_err", err, 1'b1);
        check("t4_rdata", rdata, 8'hFF);
        @(negedge clk); #1;
        check("t4_cs_after", flash_cs, 1'b0);
        check("t4_err_after", err, 1'b0);
        drain("t4");

        // Engine busy stuck high
        eng_mode = 2;
        want = 3'b001;
        wait_cs_rise("t4b", r);
        want = 3'b000;
        wait_ack("t4b", a);
        check("t4b_ack", ack, 3'b001);
        check("t4b_err", err, 1'b1);
        check("t4b_rdata", rdata, 8'hFF);
        check("t4b_cs", flash_cs, 1'b0);
        drain("t4b");
        eng_mode = 0;
        do_reset();

        // Reset asserted while waiting for the transfer to end
        eng_len = 30;
        want_addr[1] = 24'h55AA33;
        want = 3'b010;
        wait_cs_rise("t5", r);
        want = 3'b000;
        for (int n = 0; n < 50 && flash_cs; n++) begin
            @(negedge clk); #1;
        end
        check("t5_cs_fell", flash_cs, 1'b0);
        @(posedge clk); #2;
        resetn = 1'b0; flash_ready = 1'b0; eng_len = 0;
        #1;
        check("t5_async_cs", flash_cs, 1'b0);
        check("t5_async_ack", ack, 3'b000);
        check("t5_async_err", err, 1'b0);
        check("t5_async_busy", arb_busy, 1'b0);
        check("t5_async_rdata", rdata, 8'h00);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (4) @(posedge clk);
        #1 flash_ready = 1'b1;
        wait_ack("t5", a);
        check("t5_ack", ack, 3'b010);
        check("t5_err", err, 1'b0);
        check("t5_rdata", rdata, 8'hF0);
        drain("t5");

        // Port 2 arrives during port 0's transfer; port 0 keeps re-requesting
        do_reset();
        want_addr[0] = 24'h001000; want_addr[2] = 24'h002000;
        want = 3'b001;
        wait_cs_rise("t6", r);
        want = 3'b101;
        wait_ack("t6a", a);
        check("t6_first", ack, 3'b001);
        wait_ack("t6b", a);
        check("t6_second", ack, 3'b100);
        check("t6_addr", flash_addr, 24'h002000);
        want = 3'b000;
        drain("t6");

        // Randomized traffic
        rand_mode = 1;
        repeat (3000) @(posedge clk);
        #1 rand_mode = 0;
        drain("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
